avg_state_sequencer: RTL and testbench
======================================

// Module: avg_state_sequencer
// PURPOSE
//  Reader side of the 256x4 vector-generator state PROM: drives PROM address/chip-select, captures the
//  returned 4-bit next microstate and decodes it into the latch strobes and draw handshake that
//  sequence vector-RAM fetch and beam draw. Sits between the CPU VG-GO/VG-RESET strobes, the PROM,
//  vector-RAM data latches and the beam draw timer.
// PARAMETERS
//  ADDR_W        8     PROM address width = 1 (halted) + 3 (op[3:1]) + 4 (microstate)
//  DATA_W        4     PROM data width (microstate width)
//  START_MS      4'h1  microstate loaded on accepted go
//  DRAW_TIMEOUT  4096  cycles to wait for draw_done before forcing progress
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       asynchronous, active-high reset
//  go         in   1       1-cycle start pulse from CPU (VG-GO)
//  abort      in   1       1-cycle synchronous abort from CPU (VG-RESET)
//  op         in   4       opcode nibble of current latched vector-RAM word (datapath)
//  rom_addr   out  ADDR_W  PROM address {halted, op[3:1], ms}
//  rom_cs     out  1       PROM chip select, high in FETCH only
//  rom_dout   in   DATA_W  PROM data, valid 1 cycle after address sampled
//  strb       out  4       one-hot latch strobes to vector-RAM data latches (1-cycle pulses)
//  pc_inc     out  1       1-cycle vector-RAM address increment pulse
//  draw_start out  1       1-cycle pulse starting beam draw
//  draw_done  in   1       level/pulse from draw timer: vector finished
//  vg_halt    out  1       1 = sequencer halted (CPU-readable HALT)
//  timeout_err out 1       sticky: a draw timed out; cleared by go or reset
// BEHAVIOUR
//  Reset: seq state IDLE, ms=4'h0, halted=1; vg_halt=1, rom_cs=0, rom_addr=0, strb=0, pc_inc=0,
//   draw_start=0, timeout_err=0. Reset mid-operation aborts with no further strobes.
//  FSM: IDLE -> FETCH -> LOAD -> EXEC -> (FETCH | DRAW | IDLE); DRAW -> FETCH.
//  IDLE: go=1 -> ms<=START_MS, halted<=0, vg_halt<=0, timeout_err<=0, -> FETCH. go while not IDLE ignored.
//  FETCH: rom_cs=1, rom_addr={halted,op[3:1],ms} from registers (stable whole cycle) -> LOAD.
//  LOAD: ms<=rom_dout (PROM 1-cycle registered latency) -> EXEC.
//  EXEC decode of ms (outputs registered, pulse exactly the cycle after EXEC):
//   ms=4'b0000         : halted<=1, vg_halt<=1 -> IDLE
//   ms[3:2]=2'b10      : strb[ms[1:0]]=1 and pc_inc=1 -> FETCH
//   ms[3:2]=2'b11      : draw_start=1, clear timer -> DRAW
//   other values       : no action (wait microstate) -> FETCH
//  DRAW: timer counts up each cycle; draw_done=1 -> FETCH; timer==DRAW_TIMEOUT-1 -> timeout_err<=1, -> FETCH.
//   draw_done and timeout in same cycle: treat as done, timeout_err unchanged.
//  Microstep cost: 3 cycles (FETCH/LOAD/EXEC), plus DRAW wait.
//  abort=1 in any state: next cycle IDLE, halted=1, vg_halt=1, no pulses; abort beats simultaneous go.
//  strb is always one-hot or zero; never two pulses on consecutive cycles without a FETCH between.
//  Timer width = $clog2(DRAW_TIMEOUT)+1, saturates, no wrap.
// CONFIGURATION
//  AVG_SINGLE_STEP_EN defined: adds input step (1); EXEC only advances on a cycle with step=1, else holds
//   EXEC with all pulses 0; DRAW/IDLE unaffected. Undefined: no step port, EXEC always advances.
// STRUCTURE
//  Package avg_seq_pkg: seq_state_t enum (IDLE,FETCH,LOAD,EXEC,DRAW), MS_HALT=4'h0, MS_CLS_LATCH=2'b10,
//   MS_CLS_DRAW=2'b11, address field offsets.
//  Sub-module avg_draw_timer: clear/enable/count, done-at-DRAW_TIMEOUT-1 flag.
// TESTING (bench models PROM as registered 256x4 table)
//  1 reset high mid-DRAW -> same cycle vg_halt=1, strb=0, draw_start=0; after release stays IDLE.
//  2 go, op=4'h2, PROM[{0,3'b001,4'h1}]=4'b1001 -> rom_addr=8'h11 in FETCH, strb=4'b0010+pc_inc 3 cycles later.
//  3 PROM microstate 4'b1100, draw_done after 10 cycles -> one draw_start pulse, next FETCH 1 cycle after done, timeout_err=0.
//  4 draw_done never, DRAW_TIMEOUT=16 -> timeout_err=1 after 16 DRAW cycles, sequence continues; next go clears it.
//  5 PROM returns 4'b0000 -> vg_halt=1 one cycle after EXEC; go during run ignored; abort+go same cycle -> IDLE.
//  6 AVG_SINGLE_STEP_EN: step held 0 -> EXEC held, no pulses; one step pulse -> exactly one decoded action.

Source files
------------

// File: rtl/avg_seq_pkg.sv
// rtl/avg_seq_pkg.sv - shared types and constants for the vector-generator state sequencer
package avg_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        EXEC  = 3'd3,
        DRAW  = 3'd4
    } seq_state_t;

    localparam logic [3:0] MS_HALT      = 4'h0;
    localparam logic [1:0] MS_CLS_LATCH = 2'b10;
    localparam logic [1:0] MS_CLS_DRAW  = 2'b11;

    // PROM address layout: {halted, op[3:1], ms}
    localparam int ADDR_HALT_BIT = 7;
    localparam int ADDR_OP_LSB   = 4;
    localparam int ADDR_MS_LSB   = 0;

    function automatic logic [1:0] ms_class(input logic [3:0] ms);
        return ms[3:2];
    endfunction

endpackage

// File: rtl/avg_draw_timer.sv
// rtl/avg_draw_timer.sv - saturating draw wait counter with expiry flag
module avg_draw_timer #(
    parameter int DRAW_TIMEOUT = 4096,
    parameter int TW           = $clog2(DRAW_TIMEOUT) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic done
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && (cnt != {TW{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == TW'(DRAW_TIMEOUT - 1));

endmodule

// File: rtl/avg_state_sequencer.sv
// rtl/avg_state_sequencer.sv - state PROM reader and microstate decoder for vector fetch/draw
// Optional AVG_SINGLE_STEP_EN adds a step input gating advance out of EXEC.
module avg_state_sequencer
    import avg_seq_pkg::*;
#(
    parameter int              ADDR_W       = 8,
    parameter int              DATA_W       = 4,
    parameter logic [DATA_W-1:0] START_MS   = 4'h1,
    parameter int              DRAW_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
`ifdef AVG_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic              go,
    input  logic              abort,
    input  logic [3:0]        op,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_cs,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [3:0]        strb,
    output logic              pc_inc,
    output logic              draw_start,
    input  logic              draw_done,
    output logic              vg_halt,
    output logic              timeout_err
);

    seq_state_t        state, state_nxt;
    logic [DATA_W-1:0] ms;
    logic              halted;
    logic              exec_adv;
    logic              timer_done;
    logic              timer_clear;
    logic [3:0]        strb_nxt;
    logic              pc_inc_nxt;
    logic              draw_start_nxt;
    logic              op_unused;

`ifdef AVG_SINGLE_STEP_EN
    assign exec_adv = step;
`else
    assign exec_adv = 1'b1;
`endif

    assign op_unused   = op[0];
    assign timer_clear = (state == EXEC) && exec_adv && !abort && (ms_class(ms) == MS_CLS_DRAW);

    avg_draw_timer #(
        .DRAW_TIMEOUT (DRAW_TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (reset),
        .clear (timer_clear),
        .en    (state == DRAW),
        .done  (timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ms          <= MS_HALT;
            halted      <= 1'b1;
            timeout_err <= 1'b0;
            strb        <= 4'b0000;
            pc_inc      <= 1'b0;
            draw_start  <= 1'b0;
        end else begin
            state      <= state_nxt;
            strb       <= strb_nxt;
            pc_inc     <= pc_inc_nxt;
            draw_start <= draw_start_nxt;
            if (abort) begin
                ms     <= MS_HALT;
                halted <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (go) begin
                        ms          <= START_MS;
                        halted      <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                    LOAD: ms <= rom_dout;
                    EXEC: if (exec_adv && (ms == MS_HALT)) halted <= 1'b1;
                    // a simultaneous draw_done wins over expiry
                    DRAW: if (!draw_done && timer_done) timeout_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (go) state_nxt = FETCH;
                FETCH: state_nxt = LOAD;
                LOAD:  state_nxt = EXEC;
                EXEC: begin
                    if (exec_adv) begin
                        if (ms == MS_HALT)                       state_nxt = IDLE;
                        else if (ms_class(ms) == MS_CLS_DRAW)    state_nxt = DRAW;
                        else                                     state_nxt = FETCH;
                    end
                end
                DRAW:  if (draw_done || timer_done) state_nxt = FETCH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // next values of the registered pulses; they appear the cycle after EXEC
    always_comb begin
        strb_nxt       = 4'b0000;
        pc_inc_nxt     = 1'b0;
        draw_start_nxt = 1'b0;
        if (!abort && (state == EXEC) && exec_adv) begin
            case (ms_class(ms))
                MS_CLS_LATCH: begin
                    strb_nxt   = 4'b0001 << ms[1:0];
                    pc_inc_nxt = 1'b1;
                end
                MS_CLS_DRAW: draw_start_nxt = 1'b1;
                default: ;
            endcase
        end
    end

    assign rom_cs   = (state == FETCH);
    assign rom_addr = rom_cs ? ADDR_W'({halted, op[3:1], ms}) : '0;
    assign vg_halt  = halted;

endmodule

// File: tb/tb_avg_state_sequencer.sv
// tb/tb_avg_state_sequencer.sv - self-checking bench for avg_state_sequencer
module tb_avg_state_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic       draw_done = 1'b0;
    logic [3:0] op = 4'h0;
    logic [7:0] rom_addr;
    logic       rom_cs;
    logic [3:0] rom_dout;
    logic [3:0] strb;
    logic       pc_inc;
    logic       draw_start;
    logic       vg_halt;
    logic       timeout_err;
`ifdef AVG_SINGLE_STEP_EN
    logic       step = 1'b1;
`endif

    avg_state_sequencer #(
        .ADDR_W       (8),
        .DATA_W       (4),
        .START_MS     (4'h1),
        .DRAW_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef AVG_SINGLE_STEP_EN
        .step        (step),
`endif
        .go          (go),
        .abort       (abort),
        .op          (op),
        .rom_addr    (rom_addr),
        .rom_cs      (rom_cs),
        .rom_dout    (rom_dout),
        .strb        (strb),
        .pc_inc      (pc_inc),
        .draw_start  (draw_start),
        .draw_done   (draw_done),
        .vg_halt     (vg_halt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] strb;
        logic       pc;
        logic       draw;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] d;
        logic [7:0] addr;
        logic [3:0] strb;
        logic       pc;
        logic       draw;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[8];
    logic [3:0] prom[256];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         g = 0;
    int         draw_delay = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) rom_dout <= prom[rom_addr];

    // pulse scoreboard: every strobe/draw pulse must match the next queued expectation
    always @(negedge clk) begin
        exp_t e;
        if ((strb != 4'b0000) || pc_inc || draw_start) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got strb=%b pc_inc=%b draw_start=%b required none (cycle %0d)",
                         strb, pc_inc, draw_start, cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_value", {26'd0, strb, pc_inc, draw_start}, {26'd0, e.strb, e.pc, e.draw});
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // draw timer model: one-cycle draw_done draw_delay cycles into DRAW
    always @(negedge clk) begin
        if (draw_start && (draw_delay >= 0)) begin
            repeat (draw_delay) @(posedge clk);
            #1 draw_done = 1'b1;
            @(posedge clk);
            #1 draw_done = 1'b0;
        end
    end

    task automatic wait_cond(input int which, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = vg_halt;
                1:       hit = draw_start;
                default: hit = rom_cs;
            endcase
            if (hit) break;
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL %s: got no event in 300 cycles required event", name);
        end
    endtask

    task automatic kick(input logic [3:0] o);
        @(posedge clk);
        #1;
        op = o;
        go = 1'b1;
        g  = cyc;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prom[i] = 4'h0;
        vecs[0] = '{4'h2, 4'b1001, 8'h11, 4'b0010, 1'b1, 1'b0};
        vecs[1] = '{4'h3, 4'b1000, 8'h11, 4'b0001, 1'b1, 1'b0};
        vecs[2] = '{4'h5, 4'b1011, 8'h21, 4'b1000, 1'b1, 1'b0};
        vecs[3] = '{4'hF, 4'b1010, 8'h71, 4'b0100, 1'b1, 1'b0};
        vecs[4] = '{4'h4, 4'b1110, 8'h21, 4'b0000, 1'b0, 1'b1};
        vecs[5] = '{4'h9, 4'b0011, 8'h41, 4'b0000, 1'b0, 1'b0};
        vecs[6] = '{4'hC, 4'b0000, 8'h61, 4'b0000, 1'b0, 1'b0};
        vecs[7] = '{4'h7, 4'b0111, 8'h31, 4'b0000, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vg_halt", vg_halt, 1);
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_strb", strb, 0);
        chk("rst_pc_inc", pc_inc, 0);
        chk("rst_draw_start", draw_start, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            prom[{1'b0, vecs[i].op[3:1], 4'h1}] = vecs[i].d;
            if (vecs[i].d != 4'h0) prom[{1'b0, vecs[i].op[3:1], vecs[i].d}] = 4'h0;
            draw_delay = 2;
            kick(vecs[i].op);
            if ((vecs[i].strb != 4'h0) || vecs[i].pc || vecs[i].draw)
                sb.push_back('{vecs[i].strb, vecs[i].pc, vecs[i].draw, g + 4});
            chk("vec_rom_cs", rom_cs, 1);
            chk("vec_rom_addr", rom_addr, vecs[i].addr);
            wait_cond(0, "vec_halt");
            chk("vec_sb_drained", sb.size(), 0);
        end

        // draw finished by draw_done after 10 cycles
        prom[8'h31] = 4'b1100;
        prom[8'h3C] = 4'h0;
        draw_delay  = 10;
        kick(4'h6);
        sb.push_back('{4'b0000, 1'b0, 1'b1, g + 4});
        wait_cond(1, "draw_start_seen");
        repeat (10) @(negedge clk);
        chk("draw_wait_rom_cs", rom_cs, 0);
        @(negedge clk);
        chk("fetch_after_done", rom_cs, 1);
        chk("done_timeout_err", timeout_err, 0);
        wait_cond(0, "draw_halt");
        chk("draw_sb_drained", sb.size(), 0);

        // draw timeout after 16 DRAW cycles
        prom[8'h41] = 4'b1100;
        prom[8'h4C] = 4'h0;
        draw_delay  = -1;
        kick(4'h8);
        sb.push_back('{4'b0000, 1'b0, 1'b1, g + 4});
        wait_cond(1, "to_draw_start");
        repeat (15) @(negedge clk);
        chk("to_before_err", timeout_err, 0);
        chk("to_before_rom_cs", rom_cs, 0);
        @(negedge clk);
        chk("to_err_set", timeout_err, 1);
        chk("to_fetch", rom_cs, 1);
        wait_cond(0, "to_halt");
        chk("to_err_sticky", timeout_err, 1);
        prom[8'h41] = 4'h0;
        kick(4'h8);
        chk("to_err_cleared_by_go", timeout_err, 0);
        wait_cond(0, "to_halt2");

        // halt timing, go ignored during run
        prom[8'h51] = 4'b1000;
        prom[8'h58] = 4'h0;
        kick(4'hA);
        sb.push_back('{4'b0001, 1'b1, 1'b0, g + 4});
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        while (cyc < g + 6) @(negedge clk);
        chk("halt_before", vg_halt, 0);
        @(negedge clk);
        chk("halt_after_exec", vg_halt, 1);
        chk("halt_sb_drained", sb.size(), 0);

        // abort beats go in the same cycle
        @(posedge clk);
        #1;
        abort = 1'b1;
        go    = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        go    = 1'b0;
        chk("abort_go_rom_cs", rom_cs, 0);
        chk("abort_go_halt", vg_halt, 1);
        @(negedge clk);
        chk("abort_go_stay", rom_cs, 0);

        // abort in EXEC suppresses the pending strobe
        kick(4'hA);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_exec_halt", vg_halt, 1);
        chk("abort_exec_rom_cs", rom_cs, 0);
        repeat (4) @(negedge clk);
        chk("abort_no_pulse", sb.size(), 0);

        // reset asserted mid-DRAW
        prom[8'h61] = 4'b1100;
        prom[8'h6C] = 4'h0;
        kick(4'hC);
        sb.push_back('{4'b0000, 1'b0, 1'b1, g + 4});
        wait_cond(1, "rst_draw_start_seen");
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_vg_halt", vg_halt, 1);
        chk("rst_mid_strb", strb, 0);
        chk("rst_mid_draw_start", draw_start, 0);
        chk("rst_mid_rom_cs", rom_cs, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_after_idle_halt", vg_halt, 1);
        chk("rst_after_idle_cs", rom_cs, 0);

`ifdef AVG_SINGLE_STEP_EN
        step = 1'b0;
        kick(4'hA);
        repeat (8) @(negedge clk);
        chk("step_hold_rom_cs", rom_cs, 0);
        chk("step_hold_running", vg_halt, 0);
        chk("step_hold_no_pulse", sb.size(), 0);
        @(posedge clk);
        #1 step = 1'b1;
        sb.push_back('{4'b0001, 1'b1, 1'b0, cyc + 1});
        @(posedge clk);
        #1 step = 1'b0;
        repeat (6) @(negedge clk);
        chk("step_one_action", sb.size(), 0);
        chk("step_hold_halt", vg_halt, 0);
        step = 1'b1;
        wait_cond(0, "step_halt");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
